multi_channel_signal_capture: RTL and testbench
===============================================

Name: multi_channel_signal_capture

Overview:
- Parametrised successor to the fixed 8-pin signal analyser.
- Samples CHANNELS input pins every clk and detects changes on channels enabled by a runtime mask.
- Each change is stored as a {timestamp, sample} record in an internal FWFT FIFO of DEPTH entries; upstream drops nothing silently.
- Sits between the pin inputs and the data sender / SPI reader chain, which drains records through a valid/ready handshake.

Parameters:
- CHANNELS, 8: number of sampled pins; sample field width.
- TIME_W, 32: timestamp counter width.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1: width of fill-level output.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset, asynchronous, active-high.
- pins  in  CHANNELS  pin values, already synchronised upstream.
- ch_mask  in  CHANNELS  1 = channel participates in change detection.
- arm  in  1  capture enable (level).
- out_ready  in  1  consumer accepts the head record this cycle.
- clear_ovf  in  1  clears the overflow flag.
- out_valid  out  1  a head record is available.
- out_time  out  TIME_W  timestamp of the head record.
- out_data  out  CHANNELS  sample of the head record.
- out_wrap  out  1  head record is a timestamp-wrap marker (optional feature).
- level  out  CNT_W  number of records stored.
- overflow  out  1  sticky: at least one record dropped.

Behaviour:
- Reset (async, rst=1) clears:
  - time_cnt=0, cur_q=0, last_q=0, cap_time=0.
  - FIFO pointers and level=0.
  - out_valid=0, overflow=0, armed_q=0, wrap_pend=0.
  - out_time, out_data and out_wrap read as 0 while the FIFO is empty.
- time_cnt increments every cycle, regardless of arm, and wraps modulo 2^TIME_W.
- Edge N: cur_q<=pins, cap_time<=time_cnt, armed_q<=arm.
- Event at edge N+1 requires armed_q=1 and one of:
  - (cur_q ^ last_q) & ch_mask != 0;
  - armed_q rose at edge N (baseline record, forced regardless of mask).
- On an event, write {cap_time, cur_q, wrap=0} and set last_q<=cur_q. last_q updates only on events.
- ch_mask=0 with arm held: only the baseline record is produced.
- Latency: pins change sampled at edge N; record written at edge N+1; out_valid=1 after edge N+1 if the FIFO was empty (FWFT).
- Handshake:
  - A pop occurs when out_valid & out_ready; the head advances at that edge.
  - out_time and out_data stay stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - A write is accepted if level<DEPTH, or if a pop occurs in the same cycle (level unchanged).
  - Otherwise the record is dropped and overflow<=1.
- Empty FIFO: out_ready is ignored; level stays 0.
- overflow clears on clear_ovf=1 unless a drop happens in the same cycle (set wins).
- arm deassert: no new events from the next edge; stored records remain readable.
- Re-arm forces a new baseline record.
- Pointers wrap modulo DEPTH; level saturates logically at DEPTH, never above.
- At most one write per cycle.

Optional Feature:
- Macro: SIGNAL_CAPTURE_WRAP_MARKER_EN.
- Defined:
  - When time_cnt wraps from all-ones to 0 while armed_q=1, a marker record {time=0, data=last_q, wrap=1} is queued.
  - If a change event wins the same cycle, the marker is held in wrap_pend and written the next cycle that has no event.
  - A full FIFO drops the marker and sets overflow.
  - FIFO word width becomes TIME_W+CHANNELS+1.
- Undefined: out_wrap tied 0; no marker logic; FIFO word width is TIME_W+CHANNELS.

Test Plan:
- Baseline: CHANNELS=8, DEPTH=4, ch_mask=8'hFF, pins=8'hD2, raise arm at cycle 5 -> one record, out_data=8'hD2, out_time=5, level=1.
- Masked change: ch_mask=8'h0F, pins 8'hD2->8'hE2 -> no record; pins ->8'hE3 -> record out_data=8'hE3 with the timestamp of the sampling edge.
- Backpressure and overflow: out_ready=0, six changes -> level=4, overflow=1, head still holds the first record. clear_ovf pulse -> overflow=0. Then drain with out_ready=1 -> four records in order, out_valid=0 after the last pop.
- Full with simultaneous push/pop: level=4, change plus out_ready=1 in the same cycle -> level stays 4, overflow stays 0, new record is last in order.
- Async reset mid-operation: assert rst between clk edges with level=3 -> out_valid=0, level=0, overflow=0 immediately, before the next clk.
- Wrap (macro defined, TIME_W=4): arm held, no pin changes -> marker with out_wrap=1, out_time=0 after 16 cycles. Pin change on the wrap cycle -> change record first, marker next.

Source files
------------

// File: rtl/multi_channel_signal_capture.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_signal_capture
// Function : Samples CHANNELS pins every clock and stores one {timestamp,
//            sample} record per masked change in a first-word-fall-through
//            FIFO. A valid/ready port drains the records. A sticky overflow
//            flag reports every dropped record.
// Options  : `define SIGNAL_CAPTURE_WRAP_MARKER_EN to queue a wrap-marker
//            record whenever the timestamp counter rolls over while armed.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_signal_capture #(
  parameter int CHANNELS = 8,
  parameter int TIME_W   = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pins,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic                arm,
  input  logic                out_ready,
  input  logic                clear_ovf,
  output logic                out_valid,
  output logic [TIME_W-1:0]   out_time,
  output logic [CHANNELS-1:0] out_data,
  output logic                out_wrap,
  output logic [CNT_W-1:0]    level,
  output logic                overflow
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef SIGNAL_CAPTURE_WRAP_MARKER_EN
  localparam int WORD_W = TIME_W + CHANNELS + 1;
`else
  localparam int WORD_W = TIME_W + CHANNELS;
`endif

  // ------------------------------------------------------------------------
  // Sampling and event-detection state
  // ------------------------------------------------------------------------
  logic [TIME_W-1:0]   time_cnt;
  logic [TIME_W-1:0]   cap_time;
  logic [CHANNELS-1:0] cur_q;
  logic [CHANNELS-1:0] last_q;
  logic                armed_q;
  logic                armed_d;   // armed_q one edge earlier, for rise detect

  // ------------------------------------------------------------------------
  // FIFO state
  // ------------------------------------------------------------------------
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                ovf_q;

  // ------------------------------------------------------------------------
  // Combinational control
  // ------------------------------------------------------------------------
  logic                arm_rise;
  logic                chg;
  logic                ev;
  logic                wr_req;
  logic [WORD_W-1:0]   wr_word;
  logic                fifo_full;
  logic                fifo_nonempty;
  logic                pop;
  logic                wr_ok;
  logic                drop;
  logic [WORD_W-1:0]   head;

  // A rising armed_q forces a baseline record, whatever the mask says.
  assign arm_rise = armed_q & ~armed_d;
  assign chg      = |((cur_q ^ last_q) & ch_mask);
  assign ev       = armed_q & (chg | arm_rise);

`ifdef SIGNAL_CAPTURE_WRAP_MARKER_EN
  logic wrap_pend;
  logic wrap_now;
  logic mark_req;

  // A roll-over is reported in the cycle in which time_cnt is all ones, so
  // the marker is written on the same edge that takes the counter to zero.
  assign wrap_now = armed_q & (&time_cnt);
  assign mark_req = wrap_now | wrap_pend;

  // A change event has priority. The marker then waits for a free cycle.
  always_comb begin
    wr_req  = ev | mark_req;
    wr_word = ev ? {cap_time, cur_q, 1'b0}
                 : {{TIME_W{1'b0}}, last_q, 1'b1};
  end

  // Holds a marker that lost arbitration to a change event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_pend <= 1'b0;
    end else begin
      wrap_pend <= ev & mark_req;
    end
  end
`else
  // Only change or baseline events write to the FIFO.
  always_comb begin
    wr_req  = ev;
    wr_word = {cap_time, cur_q};
  end
`endif

  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == CNT_W'(DEPTH));
  // An empty FIFO ignores out_ready, so a pop needs a valid head.
  assign pop           = fifo_nonempty & out_ready;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr_ok         = wr_req & (~fifo_full | pop);
  assign drop          = wr_req & ~wr_ok;

  // ------------------------------------------------------------------------
  // Timestamp counter and pin sampling
  // ------------------------------------------------------------------------
  // Free-running timestamp. It counts with or without arm and wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_cnt <= '0;
    end else begin
      time_cnt <= time_cnt + TIME_W'(1);
    end
  end

  // Registers the pins together with the time of sampling and the arm level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      cap_time <= '0;
      armed_q  <= 1'b0;
      armed_d  <= 1'b0;
    end else begin
      cur_q    <= pins;
      cap_time <= time_cnt;
      armed_q  <= arm;
      armed_d  <= armed_q;
    end
  end

  // The change reference moves only when an event occurs. A dropped record
  // still counts as the new reference, so a lost change is not reported again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (ev) begin
      last_q <= cur_q;
    end
  end

  // ------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ------------------------------------------------------------------------
  // Storage array. It has no reset because the level counter gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Fill level. A write and a pop on the same edge leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag. A drop in the same cycle overrides a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------------------
  // Output port (first-word fall-through)
  // ------------------------------------------------------------------------
  assign head      = mem[rd_ptr];
  assign out_valid = fifo_nonempty;
  assign level     = count;
  assign overflow  = ovf_q;

  // The head fields are forced to zero while empty, so stale memory never leaks.
  always_comb begin
    out_time = '0;
    out_data = '0;
    out_wrap = 1'b0;
    if (fifo_nonempty) begin
      out_time = head[WORD_W-1 -: TIME_W];
`ifdef SIGNAL_CAPTURE_WRAP_MARKER_EN
      out_data = head[CHANNELS:1];
      out_wrap = head[0];
`else
      out_data = head[CHANNELS-1:0];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_signal_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_signal_capture
// Function : Scoreboard testbench for multi_channel_signal_capture. The
//            expected records are queued when stimulus is driven. They are
//            popped and compared when the DUT hands a record over.
//            With SIGNAL_CAPTURE_WRAP_MARKER_EN defined, the bench uses
//            TIME_W=4 and runs only the reset and wrap-marker scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_signal_capture;

  localparam int CH    = 8;
`ifdef SIGNAL_CAPTURE_WRAP_MARKER_EN
  localparam int TW    = 4;
`else
  localparam int TW    = 32;
`endif
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH-1:0]    pins = '0;
  logic [CH-1:0]    ch_mask = '1;
  logic             arm = 1'b0;
  logic             out_ready = 1'b0;
  logic             clear_ovf = 1'b0;
  logic             out_valid;
  logic [TW-1:0]    out_time;
  logic [CH-1:0]    out_data;
  logic             out_wrap;
  logic [CNT_W-1:0] level;
  logic             overflow;

  typedef struct packed {
    logic          w;
    logic [TW-1:0] t;
    logic [CH-1:0] d;
  } rec_t;

  rec_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc;

  multi_channel_signal_capture #(
    .CHANNELS(CH),
    .TIME_W  (TW),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pins     (pins),
    .ch_mask  (ch_mask),
    .arm      (arm),
    .out_ready(out_ready),
    .clear_ovf(clear_ovf),
    .out_valid(out_valid),
    .out_time (out_time),
    .out_data (out_data),
    .out_wrap (out_wrap),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter that follows the DUT timestamp: the value held here after
  // an edge equals the time_cnt the next edge will capture.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard monitor. Each handshake pops one expected record.
  always @(negedge clk) begin
    rec_t got;
    rec_t exp;
    if (!rst && out_valid && out_ready) begin
      got = {out_wrap, out_time, out_data};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got w=%0b t=%0h d=%0h, required no record",
                 got.w, got.t, got.d);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL pop_record: got w=%0b t=%0h d=%0h, required w=%0b t=%0h d=%0h",
                   got.w, got.t, got.d, exp.w, exp.t, exp.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(input logic w, input logic [TW-1:0] t, input logic [CH-1:0] d);
    rec_t r;
    r.w = w;
    r.t = t;
    r.d = d;
    return r;
  endfunction

  // Moves to 2 time units after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    arm       = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
  endtask

  // Raises out_ready until the FIFO empties, with a bound on the wait.
  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 40) begin
      nxt();
      k++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
    n_checks++; if (level !== '0)       begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %0b, required 0", overflow); end
    n_checks++; if (out_time !== '0)    begin n_fail++; $display("FAIL reset_time: got %0h, required 0", out_time); end
    n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_data: got %0h, required 0", out_data); end
    n_checks++; if (out_wrap !== 1'b0)  begin n_fail++; $display("FAIL reset_wrap: got %0b, required 0", out_wrap); end
    do_reset();
  endtask

`ifndef SIGNAL_CAPTURE_WRAP_MARKER_EN
  task automatic test_baseline();
    pins    = 8'hD2;
    ch_mask = 8'hFF;
    while (cyc != 5) nxt();
    arm = 1'b1;
    sb.push_back(mk(1'b0, TW'(5), 8'hD2));
    nxt();
    nxt();
    n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL base_valid: got %0b, required 1", out_valid); end
    n_checks++; if (level !== CNT_W'(1)) begin n_fail++; $display("FAIL base_level: got %0d, required 1", level); end
    n_checks++; if (out_data !== 8'hD2)  begin n_fail++; $display("FAIL base_data: got %0h, required d2", out_data); end
    n_checks++; if (out_time !== TW'(5)) begin n_fail++; $display("FAIL base_time: got %0d, required 5", out_time); end
  endtask

  task automatic test_masked_change();
    ch_mask = 8'h0F;
    pins    = 8'hE2;
    repeat (3) nxt();
    n_checks++; if (level !== CNT_W'(1)) begin n_fail++; $display("FAIL masked_no_record: got level %0d, required 1", level); end
    pins = 8'hE3;
    sb.push_back(mk(1'b0, TW'(cyc), 8'hE3));
    nxt();
    nxt();
    n_checks++; if (level !== CNT_W'(2)) begin n_fail++; $display("FAIL masked_record: got level %0d, required 2", level); end
    drain();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL masked_drain_valid: got %0b, required 0", out_valid); end
    n_checks++; if (sb.size() != 0)     begin n_fail++; $display("FAIL masked_drain_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    ch_mask = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      pins = 8'h10 + 8'(i);
      if (i < DEPTH) sb.push_back(mk(1'b0, TW'(cyc), 8'h10 + 8'(i)));
      nxt();
    end
    nxt();
    nxt();
    n_checks++; if (level !== CNT_W'(4)) begin n_fail++; $display("FAIL ovf_level: got %0d, required 4", level); end
    n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %0b, required 1", overflow); end
    n_checks++; if (out_data !== 8'h10)  begin n_fail++; $display("FAIL ovf_head: got %0h, required 10", out_data); end
    clear_ovf = 1'b1;
    nxt();
    clear_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b, required 0", overflow); end
    drain();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_valid: got %0b, required 0", out_valid); end
    n_checks++; if (sb.size() != 0)     begin n_fail++; $display("FAIL ovf_drain_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      pins = 8'h20 + 8'(i);
      sb.push_back(mk(1'b0, TW'(cyc), 8'h20 + 8'(i)));
      nxt();
    end
    nxt();
    nxt();
    n_checks++; if (level !== CNT_W'(4)) begin n_fail++; $display("FAIL pp_fill: got level %0d, required 4", level); end
    pins = 8'h30;
    sb.push_back(mk(1'b0, TW'(cyc), 8'h30));
    nxt();
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    n_checks++; if (level !== CNT_W'(4)) begin n_fail++; $display("FAIL pp_level: got %0d, required 4", level); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL pp_ovf: got %0b, required 0", overflow); end
    drain();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL pp_drain_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      pins = 8'h40 + 8'(i);
      sb.push_back(mk(1'b0, TW'(cyc), 8'h40 + 8'(i)));
      nxt();
    end
    nxt();
    nxt();
    n_checks++; if (level !== CNT_W'(3)) begin n_fail++; $display("FAIL ar_fill: got level %0d, required 3", level); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %0b, required 0", out_valid); end
    n_checks++; if (level !== '0)       begin n_fail++; $display("FAIL ar_level: got %0d, required 0", level); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL ar_ovf: got %0b, required 0", overflow); end
    sb.delete();
    do_reset();
  endtask
`else
  task automatic test_wrap();
    pins      = 8'hA5;
    ch_mask   = 8'hFF;
    out_ready = 1'b1;
    while (cyc != 2) nxt();
    arm = 1'b1;
    sb.push_back(mk(1'b0, TW'(2), 8'hA5));
    sb.push_back(mk(1'b1, TW'(0), 8'hA5));
    while (cyc != 30) nxt();
    // Sampled at time 14, the change lands on the wrap cycle and beats the marker.
    pins = 8'h5A;
    sb.push_back(mk(1'b0, TW'(14), 8'h5A));
    sb.push_back(mk(1'b1, TW'(0), 8'h5A));
    while (cyc != 42) nxt();
    out_ready = 1'b0;
    n_checks++; if (sb.size() != 0)     begin n_fail++; $display("FAIL wrap_left: got %0d pending, required 0", sb.size()); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid: got %0b, required 0", out_valid); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL wrap_ovf: got %0b, required 0", overflow); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SIGNAL_CAPTURE_WRAP_MARKER_EN
    test_baseline();
    test_masked_change();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
`else
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
